// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//
// Multi-cycle sequencing controller for the RV32I datapath. Every instruction
// is walked through fetch, decode, execute, memory and write-back states. The
// controller drives the shared ALU selects, the unified memory port, and the
// PC, IR and register-file write strobes. The unified memory can have a
// variable latency, so each memory access waits for a mem_ready handshake. An
// ecall halts the machine when its halt condition is true. A counter records
// how many instructions have retired.
//
// Ports
//   clk              rising-edge clock for all state
//   reset            asynchronous, active-high; returns to fetch, clears counter
//   opcode[6:0]      IR[6:0] of the latched instruction
//   mem_ready        pending memory read/write completes at this edge
//   alu_bcond        branch-condition result from the ALU
//   ecall_halt_cond  high when x17 == 10
//   pc_write         load PC
//   pc_source[1:0]   0=ALU result, 1=ALUOut, 2=ALU result with bit0 cleared
//   iord             memory address select: 0=PC, 1=ALUOut
//   mem_read         memory read request
//   mem_write        memory write request
//   ir_write         latch IR and old_pc
//   reg_write        register-file write enable
//   wb_sel[1:0]      0=ALUOut, 1=MDR, 2=old_pc+4
//   alu_src_a[1:0]   0=PC, 1=A (rs1), 2=old_pc
//   alu_src_b[1:0]   0=B (rs2), 1=constant 4, 2=imm
//   alu_op[1:0]      0=add, 1=branch compare, 2=funct-decoded
//   is_halted        sticky halt indication
//   retire_count     retired-instruction count, wraps modulo 2^CNT_W

module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             alu_bcond,
  input  logic             ecall_halt_cond,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF,
    S_ID,
    S_EX_R,
    S_EX_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_EX_BR,
    S_EX_JAL,
    S_EX_JALR,
    S_ECALL,
    S_HALT
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] retire_count_reg;
  logic             retire;

  // These strobes and requests are produced ungated here. They are masked by
  // reset below so that a reset drops them without waiting for a clock edge.
  logic pc_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_read_raw;
  logic mem_write_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IF;
      retire_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        retire_count_reg <= retire_count_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    pc_source     = 2'd0;
    iord          = 1'b0;
    wb_sel        = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    retire        = 1'b0;

    case (state_reg)
      S_IF: begin
        // PC+4 is computed in the ALU. It is written together with IR on the
        // same edge that completes the fetch.
        mem_read_raw = 1'b1;
        alu_src_b    = 2'd1;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) begin
          state_next = S_ID;
        end
      end

      S_ID: begin
        // Branch/jal target old_pc+imm is computed here into ALUOut.
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        case (opcode)
          OP_R:     state_next = S_EX_R;
          OP_I:     state_next = S_EX_I;
          OP_LOAD,
          OP_STORE: state_next = S_MEM_ADDR;
          OP_BR:    state_next = S_EX_BR;
          OP_JAL:   state_next = S_EX_JAL;
          OP_JALR:  state_next = S_EX_JALR;
          OP_ECALL: state_next = S_ECALL;
          default: begin
            // An unknown opcode is executed as a nop and still retires.
            state_next = S_IF;
            retire     = 1'b1;
          end
        endcase
      end

      S_EX_R: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd0;
        alu_op     = 2'd2;
        state_next = S_WB_ALU;
      end

      S_EX_I: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        alu_op     = 2'd2;
        state_next = S_WB_ALU;
      end

      S_MEM_ADDR: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        iord         = 1'b1;
        mem_read_raw = 1'b1;
        if (mem_ready) begin
          state_next = S_WB_MEM;
        end
      end

      S_MEM_WR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          state_next = S_IF;
          retire     = 1'b1;
        end
      end

      S_WB_ALU: begin
        reg_write_raw = 1'b1;
        wb_sel        = 2'd0;
        state_next    = S_IF;
        retire        = 1'b1;
      end

      S_WB_MEM: begin
        reg_write_raw = 1'b1;
        wb_sel        = 2'd1;
        state_next    = S_IF;
        retire        = 1'b1;
      end

      S_EX_BR: begin
        // When the branch is not taken, the PC+4 written during fetch is kept.
        alu_src_a    = 2'd1;
        alu_src_b    = 2'd0;
        alu_op       = 2'd1;
        pc_source    = 2'd1;
        pc_write_raw = alu_bcond;
        state_next   = S_IF;
        retire       = 1'b1;
      end

      S_EX_JAL: begin
        reg_write_raw = 1'b1;
        wb_sel        = 2'd2;
        pc_write_raw  = 1'b1;
        pc_source     = 2'd1;
        state_next    = S_IF;
        retire        = 1'b1;
      end

      S_EX_JALR: begin
        // A was latched in ID, so a write to rd == rs1 here cannot corrupt
        // the target that is being computed.
        alu_src_a     = 2'd1;
        alu_src_b     = 2'd2;
        pc_write_raw  = 1'b1;
        pc_source     = 2'd2;
        reg_write_raw = 1'b1;
        wb_sel        = 2'd2;
        state_next    = S_IF;
        retire        = 1'b1;
      end

      S_ECALL: begin
        // The halting ecall also retires.
        state_next = ecall_halt_cond ? S_HALT : S_IF;
        retire     = 1'b1;
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IF;
      end
    endcase
  end

  assign pc_write     = pc_write_raw  & ~reset;
  assign ir_write     = ir_write_raw  & ~reset;
  assign reg_write    = reg_write_raw & ~reset;
  assign mem_read     = mem_read_raw  & ~reset;
  assign mem_write    = mem_write_raw & ~reset;
  assign is_halted    = (state_reg == S_HALT);
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm.
// All outputs except retire_count are packed into one vector and compared
// with hand-built per-state constants every cycle. The packed order is:
// {pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_write,
//  wb_sel, alu_src_a, alu_src_b, alu_op, is_halted}.
// A 4-bit retire counter is used so that the modulo wrap is exercised.

module tb_mc_control_fsm;

  localparam int CW = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  //                              pw   ps    iord mr   mw   irw  rw   wb    a     b     op    h
  localparam logic [16:0] RST_V  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd1,2'd0,1'b0};
  localparam logic [16:0] IF_RDY = {1'b1,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd1,2'd0,1'b0};
  localparam logic [16:0] IF_WT  = {1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,2'd1,2'd0,1'b0};
  localparam logic [16:0] ID_V   = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd2,2'd0,1'b0};
  localparam logic [16:0] EXR_V  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd0,2'd2,1'b0};
  localparam logic [16:0] EXI_V  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,2'd2,1'b0};
  localparam logic [16:0] MA_V   = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,2'd0,1'b0};
  localparam logic [16:0] MRD_V  = {1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] MWR_V  = {1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] WBA_V  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] WBM_V  = {1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] BRT_V  = {1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd0,2'd1,1'b0};
  localparam logic [16:0] BRN_V  = {1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd0,2'd1,1'b0};
  localparam logic [16:0] JAL_V  = {1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,2'd0,2'd0,1'b0};
  localparam logic [16:0] JALR_V = {1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd1,2'd2,2'd0,1'b0};
  localparam logic [16:0] ECL_V  = 17'd0;
  localparam logic [16:0] HALT_V = 17'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          mem_ready = 1'b0;
  logic          alu_bcond = 1'b0;
  logic          ecall_halt_cond = 1'b0;
  logic          pc_write;
  logic [1:0]    pc_source;
  logic          iord;
  logic          mem_read;
  logic          mem_write;
  logic          ir_write;
  logic          reg_write;
  logic [1:0]    wb_sel;
  logic [1:0]    alu_src_a;
  logic [1:0]    alu_src_b;
  logic [1:0]    alu_op;
  logic          is_halted;
  logic [CW-1:0] retire_count;
  logic [16:0]   outs;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode          (opcode),
    .mem_ready       (mem_ready),
    .alu_bcond       (alu_bcond),
    .ecall_halt_cond (ecall_halt_cond),
    .pc_write        (pc_write),
    .pc_source       (pc_source),
    .iord            (iord),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .ir_write        (ir_write),
    .reg_write       (reg_write),
    .wb_sel          (wb_sel),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .alu_op          (alu_op),
    .is_halted       (is_halted),
    .retire_count    (retire_count)
  );

  assign outs = {pc_write, pc_source, iord, mem_read, mem_write, ir_write,
                 reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted};

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 reset = 1'b1;
    #1 checks++;
    if (outs !== RST_V) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=%h", outs, RST_V);
    end
    checks++;
    if (retire_count !== CW'(0)) begin
      failures++;
      $display("FAIL reset_retire got=%0d exp=0", retire_count);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("txn reset retire_count=%0d", retire_count);
  endtask

  task automatic test_r_type();
    logic [16:0] ev [4] = '{IF_RDY, ID_V, EXR_V, WBA_V};
    opcode = OP_R;
    for (int i = 0; i < 4; i++) begin
      #1 mem_ready = 1'b1;
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL r_type cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    exp_ret++;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL r_type_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn r_type retire_count=%0d", retire_count);
  endtask

  task automatic test_if_wait();
    logic [16:0] ev [6] = '{IF_WT, IF_WT, IF_RDY, ID_V, EXI_V, WBA_V};
    bit          rd [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = OP_I;
    for (int i = 0; i < 6; i++) begin
      #1 mem_ready = rd[i];
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL if_wait cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    exp_ret++;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL if_wait_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn i_type_fetch_wait retire_count=%0d", retire_count);
  endtask

  task automatic test_load();
    logic [16:0] ev [8] = '{IF_RDY, ID_V, MA_V, MRD_V, MRD_V, MRD_V, MRD_V, WBM_V};
    bit          rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_LOAD;
    for (int i = 0; i < 8; i++) begin
      #1 mem_ready = rd[i];
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL load cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    exp_ret++;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL load_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn load_wait3 retire_count=%0d", retire_count);
  endtask

  task automatic test_store();
    logic [16:0] ev [5] = '{IF_RDY, ID_V, MA_V, MWR_V, MWR_V};
    bit          rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = OP_STORE;
    for (int i = 0; i < 5; i++) begin
      #1 mem_ready = rd[i];
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL store cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    exp_ret++;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL store_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn store_wait1 retire_count=%0d", retire_count);
  endtask

  task automatic test_branch();
    logic [16:0] ev [6] = '{IF_RDY, ID_V, BRT_V, IF_RDY, ID_V, BRN_V};
    bit          bc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    opcode = OP_BR;
    for (int i = 0; i < 6; i++) begin
      #1 mem_ready = 1'b1;
      alu_bcond = bc[i];
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL branch cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    alu_bcond = 1'b0;
    exp_ret += 2;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL branch_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn branch_taken_and_not retire_count=%0d", retire_count);
  endtask

  task automatic test_jumps();
    logic [16:0] ev [6] = '{IF_RDY, ID_V, JAL_V, IF_RDY, ID_V, JALR_V};
    logic [6:0]  op [6] = '{OP_JAL, OP_JAL, OP_JAL, OP_JALR, OP_JALR, OP_JALR};
    for (int i = 0; i < 6; i++) begin
      #1 mem_ready = 1'b1;
      opcode = op[i];
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL jumps cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    exp_ret += 2;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL jumps_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn jal_jalr retire_count=%0d", retire_count);
  endtask

  task automatic test_nop_ecall();
    // Unknown opcode, then an ecall that does not halt. The final IF cycle
    // is held without ready so that the next task starts in fetch.
    logic [16:0] ev [6] = '{IF_RDY, ID_V, IF_RDY, ID_V, ECL_V, IF_WT};
    logic [6:0]  op [6] = '{OP_BAD, OP_BAD, OP_ECALL, OP_ECALL, OP_ECALL, OP_ECALL};
    bit          rd [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ecall_halt_cond = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 mem_ready = rd[i];
      opcode = op[i];
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL nop_ecall cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    exp_ret += 2;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL nop_ecall_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn nop_and_ecall_nohalt retire_count=%0d", retire_count);
  endtask

  task automatic test_wrap();
    opcode = OP_BAD;
    for (int i = 0; i < 16; i++) begin
      #1 mem_ready = 1'b1;
      #1 checks++;
      if (outs !== ((i % 2 == 0) ? IF_RDY : ID_V)) begin
        failures++;
        $display("FAIL wrap cyc%0d got=%h", i + 1, outs);
      end
      @(posedge clk);
    end
    exp_ret += 8;
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL wrap_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn eight_nops_wrap retire_count=%0d", retire_count);
  endtask

  task automatic test_reset_mid_store();
    logic [16:0] ev [4] = '{IF_RDY, ID_V, MA_V, MWR_V};
    bit          rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = OP_STORE;
    for (int i = 0; i < 4; i++) begin
      #1 mem_ready = rd[i];
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL rst_store cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      if (i < 3) @(posedge clk);
    end
    // Reset is asserted mid-cycle, with no clock edge, while the write waits.
    #1 reset = 1'b1;
    #1 checks++;
    if (mem_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_store_mem_write got=%b exp=0", mem_write);
    end
    checks++;
    if (outs !== RST_V) begin
      failures++;
      $display("FAIL rst_store_outs got=%h exp=%h", outs, RST_V);
    end
    exp_ret = 0;
    checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL rst_store_retire got=%0d exp=0", retire_count);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    $display("txn reset_mid_store retire_count=%0d", retire_count);
  endtask

  task automatic test_halt();
    logic [16:0] ev [3] = '{IF_RDY, ID_V, ECL_V};
    opcode = OP_ECALL;
    ecall_halt_cond = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 mem_ready = 1'b1;
      #1 checks++;
      if (outs !== ev[i]) begin
        failures++;
        $display("FAIL halt_seq cyc%0d got=%h exp=%h", i + 1, outs, ev[i]);
      end
      @(posedge clk);
    end
    exp_ret++;
    for (int i = 0; i < 100; i++) begin
      #1 mem_ready = 1'($urandom_range(0, 1));
      alu_bcond = 1'($urandom_range(0, 1));
      ecall_halt_cond = 1'($urandom_range(0, 1));
      opcode = 7'($urandom_range(0, 127));
      #1 checks++;
      if (outs !== HALT_V) begin
        failures++;
        $display("FAIL halt_hold cyc%0d got=%h exp=%h", i + 4, outs, HALT_V);
      end
      @(posedge clk);
    end
    #1 checks++;
    if (retire_count !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL halt_retire got=%0d exp=%0d", retire_count, CW'(exp_ret));
    end
    $display("txn ecall_halt retire_count=%0d", retire_count);
    // Reset is the only way out of HALT.
    reset = 1'b1;
    #1 checks++;
    if (outs !== RST_V) begin
      failures++;
      $display("FAIL halt_reset got=%h exp=%h", outs, RST_V);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    #1 checks++;
    if (outs !== IF_RDY) begin
      failures++;
      $display("FAIL halt_refetch got=%h exp=%h", outs, IF_RDY);
    end
    $display("txn reset_from_halt retire_count=%0d", retire_count);
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_if_wait();
    test_load();
    test_store();
    test_branch();
    test_jumps();
    test_nop_ecall();
    test_wrap();
    test_reset_mid_store();
    test_r_type();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
